// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encoding, IR field positions and opcode helpers for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN        = 2'd0,
    PC_MEM_WAIT   = 2'd1,
    PC_HALT_DRAIN = 2'd2,
    PC_HALTED     = 2'd3
  } pc_state_t;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLLV = 6'h06;
  localparam logic [5:0] OP_SRLV = 6'h07;
  localparam logic [5:0] OP_LW   = 6'h08;
  localparam logic [5:0] OP_LH   = 6'h09;
  localparam logic [5:0] OP_LD   = 6'h0a;
  localparam logic [5:0] OP_SW   = 6'h0b;
  localparam logic [5:0] OP_SH   = 6'h0c;
  localparam logic [5:0] OP_SD   = 6'h0d;
  localparam logic [5:0] OP_BEQ  = 6'h0e;
  localparam logic [5:0] OP_BNE  = 6'h0f;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h3f;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  // Opcodes that read rt as a source operand rather than writing it.
  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLLV, OP_SRLV,
      OP_SW, OP_SH, OP_SD, OP_BEQ, OP_BNE: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline <-> sequencing controller signal bundle
interface pipe_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic [WIDTH-1:0] IR_ID;
  logic [WIDTH-1:0] IR_EXE;
  logic             IsBranchTaken;
  logic [WIDTH-3:0] BranchAddr;
  logic             MemReq;
  logic             MemReady;
  logic             StallIF;
  logic             StallID;
  logic             IsStall;
  logic             StallMEM;
  logic             FlushIF;
  logic             FlushID;
  logic             BubbleEXE;
  logic             Redirect;
  logic [WIDTH-3:0] RedirectAddr;
  logic             Halted;
  logic             MemError;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] StallCount;

  // master is the controller, slave is the pipeline datapath
  modport master (
    input  IR_ID, IR_EXE, IsBranchTaken, BranchAddr, MemReq, MemReady,
    output StallIF, StallID, IsStall, StallMEM, FlushIF, FlushID, BubbleEXE,
           Redirect, RedirectAddr, Halted, MemError, CycleCount, StallCount
  );

  modport slave (
    output IR_ID, IR_EXE, IsBranchTaken, BranchAddr, MemReq, MemReady,
    input  StallIF, StallID, IsStall, StallMEM, FlushIF, FlushID, BubbleEXE,
           Redirect, RedirectAddr, Halted, MemError, CycleCount, StallCount
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard detection between ID and EXE
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] ir_id,
  input  logic [WIDTH-1:0] ir_exe,
  output logic             lu
);

  logic [5:0] op_id;
  logic [5:0] op_exe;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic [4:0] rt_exe;
  logic       unused_fields;

  assign op_id  = ir_id[OP_HI:OP_LO];
  assign rs_id  = ir_id[RS_HI:RS_LO];
  assign rt_id  = ir_id[RT_HI:RT_LO];
  assign op_exe = ir_exe[OP_HI:OP_LO];
  assign rt_exe = ir_exe[RT_HI:RT_LO];

  assign unused_fields = ^{ir_id[RT_LO-1:0], ir_exe[RS_HI:RS_LO], ir_exe[RT_LO-1:0]};

  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign lu = is_load(op_exe) && (rt_exe != 5'd0) &&
              ((rt_exe == rs_id) || (uses_rt(op_id) && (rt_exe == rt_id)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stalls, flushes, redirect, memory wait, halt drain, counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.master bus
);

  pc_state_t        state;
  logic [31:0]      wait_cnt;
  logic [31:0]      drain_cnt;
  logic             mem_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic lu;
  logic mem_stall;
  logic halt_id;
  logic wait_timeout;
  logic count_stall;
  logic stall_if, stall_id, stall_exe, stall_mem;
  logic flush_if, flush_id, bubble_exe, redirect;

  pipe_ctrl_hazard_detect #(.WIDTH(WIDTH)) u_hazard (
    .ir_id  (bus.IR_ID),
    .ir_exe (bus.IR_EXE),
    .lu     (lu)
  );

  assign mem_stall    = bus.MemReq & ~bus.MemReady;
  assign halt_id      = (bus.IR_ID[OP_HI:OP_LO] == OP_HALT);
  assign wait_timeout = (MEM_TIMEOUT != 0) && !bus.MemReady &&
                        ((wait_cnt + 32'd1) == 32'(MEM_TIMEOUT));

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_exe   = 1'b0;
    stall_mem   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    bubble_exe  = 1'b0;
    redirect    = 1'b0;
    count_stall = 1'b0;
    case (state)
      PC_RUN, PC_HALT_DRAIN: begin
        // A pending memory access freezes EXE, so any taken branch is re-presented later.
        if (mem_stall) begin
          {stall_if, stall_id, stall_exe, stall_mem} = 4'b1111;
          count_stall = 1'b1;
        end else if (bus.IsBranchTaken) begin
          redirect = 1'b1;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (state == PC_HALT_DRAIN) begin
          stall_if = 1'b1;
          flush_if = 1'b1;
        end else if (lu) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          bubble_exe  = 1'b1;
          count_stall = 1'b1;
        end else if (halt_id) begin
          stall_if = 1'b1;
          flush_if = 1'b1;
        end
      end
      PC_MEM_WAIT: begin
        {stall_if, stall_id, stall_exe, stall_mem} = 4'b1111;
        count_stall = 1'b1;
      end
      PC_HALTED: begin
        {stall_if, stall_id, stall_exe, stall_mem} = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PC_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      mem_err   <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state != PC_HALTED) && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (count_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        PC_RUN: begin
          if (mem_stall) begin
            state    <= PC_MEM_WAIT;
            wait_cnt <= '0;
          end else if (!bus.IsBranchTaken && !lu && halt_id) begin
            state     <= PC_HALT_DRAIN;
            drain_cnt <= 32'(DRAIN_CYCLES);
          end
        end
        PC_MEM_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (bus.MemReady) begin
            state <= PC_RUN;
          end else if (wait_timeout) begin
            mem_err <= 1'b1;
            state   <= PC_HALTED;
          end
        end
        PC_HALT_DRAIN: begin
          if (!mem_stall) begin
            if (bus.IsBranchTaken)
              state <= PC_RUN;
            else if (drain_cnt <= 32'd1)
              state <= PC_HALTED;
            else
              drain_cnt <= drain_cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Everything reads as idle while rst is held, regardless of the state being left.
  assign bus.StallIF      = stall_if & ~rst;
  assign bus.StallID      = stall_id & ~rst;
  assign bus.IsStall      = stall_exe & ~rst;
  assign bus.StallMEM     = stall_mem & ~rst;
  assign bus.FlushIF      = flush_if & ~rst;
  assign bus.FlushID      = flush_id & ~rst;
  assign bus.BubbleEXE    = bubble_exe & ~rst;
  assign bus.Redirect     = redirect & ~rst;
  assign bus.RedirectAddr = (redirect & ~rst) ? bus.BranchAddr : '0;
  assign bus.Halted       = (state == PC_HALTED) & ~rst;
  assign bus.MemError     = mem_err & ~rst;
  assign bus.CycleCount   = rst ? '0 : cycle_cnt;
  assign bus.StallCount   = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural model and directed vectors
module tb_pipe_ctrl;

  localparam int TIMEOUT = 8;
  localparam int DRAIN   = 3;

  localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, SUB = 6'h02, AND_ = 6'h03, OR_ = 6'h04,
                         XOR_ = 6'h05, SLLV = 6'h06, SRLV = 6'h07, LW = 6'h08, LH = 6'h09,
                         LD = 6'h0a, SW = 6'h0b, SH = 6'h0c, SD = 6'h0d, BEQ = 6'h0e,
                         BNE = 6'h0f, ADDI = 6'h10, HALT = 6'h3f;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  pipe_ctrl_if #(.WIDTH(32), .CNT_W(32)) bus ();

  pipe_ctrl #(.WIDTH(32), .MEM_TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  // Load-use rule written directly from the instruction-field description.
  function automatic bit model_lu(input logic [31:0] id, input logic [31:0] ex);
    logic [5:0] eop, iop;
    logic [4:0] ert;
    bit reads_rt;
    eop = ex[31:26];
    ert = ex[20:16];
    iop = id[31:26];
    reads_rt = iop inside {ADD, SUB, AND_, OR_, XOR_, SLLV, SRLV, SW, SH, SD, BEQ, BNE};
    if (!(eop inside {LW, LH, LD}) || ert == 5'd0) return 1'b0;
    return (ert == id[25:21]) || (reads_rt && ert == id[20:16]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc_n, act, exp);
    end
  endtask

  // Behavioural model state: which situation the core is in, described by counts.
  int          m_wait   = -1;   // MEM_WAIT cycles elapsed, -1 when not waiting
  int          m_drain  = 0;    // drain cycles still to go
  bit          m_halted = 0;
  bit          m_err    = 0;
  logic [31:0] m_cycles = '0;
  logic [31:0] m_stalls = '0;

  bit          e_sif, e_sid, e_sexe, e_smem, e_fif, e_fid, e_bub, e_red, e_halt, e_err;
  logic [29:0] e_addr;
  logic [31:0] e_cyc, e_stl;

  always @(negedge clk) begin
    bit blocked, hz;
    cyc_n++;
    blocked = bus.MemReq && !bus.MemReady;
    hz      = model_lu(bus.IR_ID, bus.IR_EXE);
    {e_sif, e_sid, e_sexe, e_smem, e_fif, e_fid, e_bub, e_red} = '0;
    e_addr = '0;
    e_halt = m_halted && !rst;
    e_err  = m_err && !rst;
    e_cyc  = rst ? 32'd0 : m_cycles;
    e_stl  = rst ? 32'd0 : m_stalls;
    if (rst) begin
      m_wait = -1; m_drain = 0; m_halted = 0; m_err = 0; m_cycles = '0; m_stalls = '0;
    end else if (m_halted) begin
      {e_sif, e_sid, e_sexe, e_smem} = 4'hf;
    end else begin
      m_cycles++;
      if (m_wait >= 0) begin
        {e_sif, e_sid, e_sexe, e_smem} = 4'hf;
        m_stalls++;
        if (bus.MemReady) m_wait = -1;
        else begin
          m_wait++;
          if (TIMEOUT != 0 && m_wait == TIMEOUT) begin m_halted = 1; m_err = 1; m_wait = -1; end
        end
      end else if (blocked) begin
        {e_sif, e_sid, e_sexe, e_smem} = 4'hf;
        m_stalls++;
        if (m_drain == 0) m_wait = 0;
      end else if (bus.IsBranchTaken) begin
        e_red = 1; e_addr = bus.BranchAddr; e_fif = 1; e_fid = 1; m_drain = 0;
      end else if (m_drain > 0) begin
        e_sif = 1; e_fif = 1;
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (hz) begin
        e_sif = 1; e_sid = 1; e_bub = 1; m_stalls++;
      end else if (bus.IR_ID[31:26] == HALT) begin
        e_sif = 1; e_fif = 1; m_drain = DRAIN;
      end
    end
    chk("m_StallIF",      64'(bus.StallIF),      64'(e_sif));
    chk("m_StallID",      64'(bus.StallID),      64'(e_sid));
    chk("m_IsStall",      64'(bus.IsStall),      64'(e_sexe));
    chk("m_StallMEM",     64'(bus.StallMEM),     64'(e_smem));
    chk("m_FlushIF",      64'(bus.FlushIF),      64'(e_fif));
    chk("m_FlushID",      64'(bus.FlushID),      64'(e_fid));
    chk("m_BubbleEXE",    64'(bus.BubbleEXE),    64'(e_bub));
    chk("m_Redirect",     64'(bus.Redirect),     64'(e_red));
    chk("m_RedirectAddr", 64'(bus.RedirectAddr), 64'(e_addr));
    chk("m_Halted",       64'(bus.Halted),       64'(e_halt));
    chk("m_MemError",     64'(bus.MemError),     64'(e_err));
    chk("m_CycleCount",   64'(bus.CycleCount),   64'(e_cyc));
    chk("m_StallCount",   64'(bus.StallCount),   64'(e_stl));
  end

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input bit br,
                       input logic [29:0] ba, input bit req, input bit rdy);
    bus.IR_ID = id; bus.IR_EXE = ex; bus.IsBranchTaken = br;
    bus.BranchAddr = ba; bus.MemReq = req; bus.MemReady = rdy;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 0, 30'h0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    settle();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    settle();
    chk("rst_StallIF", 64'(bus.StallIF), 64'd0);
    chk("rst_Halted",  64'(bus.Halted),  64'd0);
    adv();
    settle();
    adv();
    rst = 1'b0;
    settle();
    chk("rst_CycleCount", bus.CycleCount, 64'd0);
    chk("rst_MemError",   64'(bus.MemError), 64'd0);
    adv();

    // load-use
    do_reset();
    drive(mk(ADD, 5, 1), mk(LW, 2, 5), 0, 0, 0, 0);
    settle();
    chk("lu_StallIF",   64'(bus.StallIF),   64'd1);
    chk("lu_StallID",   64'(bus.StallID),   64'd1);
    chk("lu_BubbleEXE", 64'(bus.BubbleEXE), 64'd1);
    adv();
    drive(mk(ADD, 5, 1), mk(NOP, 0, 0), 0, 0, 0, 0);
    settle();
    chk("lu_release",    64'(bus.StallIF), 64'd0);
    chk("lu_StallCount", bus.StallCount,   64'd1);
    adv();
    drive(mk(ADD, 0, 0), mk(LW, 2, 0), 0, 0, 0, 0);
    settle();
    chk("lu_rt0", 64'(bus.StallIF), 64'd0);
    adv();
    drive(mk(SW, 1, 7), mk(LH, 3, 7), 0, 0, 0, 0);
    settle();
    chk("lu_id_rt", 64'(bus.BubbleEXE), 64'd1);
    adv();
    drive(mk(ADDI, 1, 7), mk(LD, 3, 7), 0, 0, 0, 0);
    settle();
    chk("lu_addi_rt", 64'(bus.StallIF), 64'd0);
    adv();
    drive(mk(SUB, 9, 2), mk(ADD, 3, 9), 0, 0, 0, 0);
    adv();
    drive(mk(BNE, 4, 9), mk(LD, 3, 9), 0, 0, 0, 0);
    adv();

    // branch beats a load-use pattern
    drive(mk(ADD, 5, 1), mk(LW, 2, 5), 1, 30'h40, 0, 0);
    settle();
    chk("br_Redirect",     64'(bus.Redirect),     64'd1);
    chk("br_RedirectAddr", 64'(bus.RedirectAddr), 64'h40);
    chk("br_FlushID",      64'(bus.FlushID),      64'd1);
    chk("br_BubbleEXE",    64'(bus.BubbleEXE),    64'd0);
    adv();
    idle();
    adv();

    // memory wait with a branch held during the wait
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(32'h0, 32'h0, i >= 2, 30'h80, i <= 5, i == 5);
      settle();
      if (i == 5) begin
        chk("mw_IsStall",  64'(bus.IsStall),  64'd1);
        chk("mw_Redirect", 64'(bus.Redirect), 64'd0);
      end
      if (i == 6) begin
        chk("mw_release",    64'(bus.StallMEM), 64'd0);
        chk("mw_late_br",    64'(bus.Redirect), 64'd1);
        chk("mw_StallCount", bus.StallCount,    64'd5);
        chk("mw_CycleCount", bus.CycleCount,    64'd5);
      end
      adv();
    end
    idle();
    adv();

    // timeout
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(32'h0, 32'h0, 0, 0, 1, 0);
      settle();
      if (i == 9) chk("to_not_yet", 64'(bus.Halted), 64'd0);
      if (i == 10) begin
        chk("to_Halted",     64'(bus.Halted),   64'd1);
        chk("to_MemError",   64'(bus.MemError), 64'd1);
        chk("to_StallCount", bus.StallCount,    64'd9);
      end
      if (i == 12) chk("to_CycleFrozen", bus.CycleCount, 64'd9);
      adv();
    end

    // reset out of HALTED clears the sticky error
    rst = 1'b1;
    settle();
    chk("rh_MemError", 64'(bus.MemError), 64'd0);
    adv();
    rst = 1'b0;
    idle();
    settle();
    chk("rh_Halted", 64'(bus.Halted), 64'd0);
    adv();

    // reset in the middle of a memory wait
    for (int i = 1; i <= 3; i++) begin
      drive(32'h0, 32'h0, 0, 0, 1, 0);
      adv();
    end
    rst = 1'b1;
    settle();
    chk("rw_IsStall", 64'(bus.IsStall), 64'd0);
    adv();
    rst = 1'b0;
    idle();
    settle();
    chk("rw_StallMEM",   64'(bus.StallMEM), 64'd0);
    chk("rw_CycleCount", bus.CycleCount,    64'd0);
    adv();

    // halt drain to HALTED
    do_reset();
    drive(mk(HALT, 0, 0), 32'h0, 0, 0, 0, 0);
    settle();
    chk("hd_FlushIF", 64'(bus.FlushIF), 64'd1);
    adv();
    for (int i = 1; i <= 4; i++) begin
      idle();
      settle();
      if (i == 3) chk("hd_draining", 64'(bus.Halted), 64'd0);
      if (i == 4) chk("hd_Halted",   64'(bus.Halted), 64'd1);
      adv();
    end

    // halt cancelled by a taken branch on the second drain cycle
    do_reset();
    drive(mk(HALT, 0, 0), 32'h0, 0, 0, 0, 0);
    adv();
    idle();
    adv();
    drive(32'h0, 32'h0, 1, 30'h100, 0, 0);
    settle();
    chk("hb_Redirect",     64'(bus.Redirect),     64'd1);
    chk("hb_RedirectAddr", 64'(bus.RedirectAddr), 64'h100);
    adv();
    for (int i = 1; i <= 4; i++) begin
      idle();
      settle();
      if (i == 4) begin
        chk("hb_not_halted", 64'(bus.Halted),  64'd0);
        chk("hb_running",    64'(bus.StallIF), 64'd0);
      end
      adv();
    end

    // reset in the middle of a drain
    do_reset();
    drive(mk(HALT, 0, 0), 32'h0, 0, 0, 0, 0);
    adv();
    idle();
    adv();
    rst = 1'b1;
    settle();
    chk("rd_StallIF", 64'(bus.StallIF), 64'd0);
    adv();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      idle();
      settle();
      if (i == 1) chk("rd_CycleCount", bus.CycleCount, 64'd0);
      if (i == 5) chk("rd_no_halt", 64'(bus.Halted), 64'd0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (IF/ID/EXE/MEM/WB). It generates per-stage stall, flush and bubble controls and drives the IsStall input of EXE_mod. It detects load-use hazards, applies the branch redirect from EXE, waits out slow memory with a timeout, drains and halts on HALT, and keeps cycle and stall counters.

Parameters:
WIDTH, 32, datapath width (from params.v); PC width is WIDTH-2
MEM_TIMEOUT, 255, maximum cycles in MEM_WAIT before error; 0 disables the timeout
DRAIN_CYCLES, 3, cycles to drain EXE/MEM/WB after HALT leaves ID
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
IR_ID  in  WIDTH  instruction currently in ID
IR_EXE  in  WIDTH  instruction currently in EXE
IsBranchTaken  in  1  from EXE, branch/jump resolved taken
BranchAddr  in  WIDTH-2  target from EXE
MemReq  in  1  MEM stage holds a load/store
MemReady  in  1  memory completes the access this cycle
StallIF  out  1  hold PC
StallID  out  1  hold the IF/ID register
IsStall  out  1  hold EXE (to EXE_mod)
StallMEM  out  1  hold MEM
FlushIF  out  1  discard the fetched instruction
FlushID  out  1  replace ID with NOP
BubbleEXE  out  1  inject NOP into EXE next cycle
Redirect  out  1  load PC with RedirectAddr
RedirectAddr  out  WIDTH-2  new PC
Halted  out  1  core stopped
MemError  out  1  sticky timeout flag
CycleCount  out  CNT_W  cycles since reset, excluding HALTED
StallCount  out  CNT_W  cycles with StallIF due to hazard or memory wait

Behaviour:
- Outputs are combinational from the registered state and the current inputs. Counters, flags and state are registered.
- Reset: state is RUN and all counters are 0. MemError=0, Halted=0, and every stall, flush and redirect output is 0 in the reset cycle.
- Field rules: opcode = IR[31:26], rs = IR[25:21], rt = IR[20:16].
- Load-use hazard (LU): EXE opcode is LW, LH or LD, and EXE rt != 0, and EXE rt matches either:
  - ID rs, or
  - ID rt when the ID opcode uses rt (ADD, SUB, AND, OR, XOR, SLLV, SRLV, SW, SH, SD, BEQ, BNE).
- States: RUN, MEM_WAIT, HALT_DRAIN, HALTED.
- RUN priority, highest first:
  - MemReq & !MemReady:
    - Assert StallIF, StallID, IsStall, StallMEM.
    - Go to MEM_WAIT and clear the wait counter.
    - A branch taken in the same cycle is deferred: EXE is frozen, so it is re-presented.
  - IsBranchTaken:
    - Redirect=1, RedirectAddr=BranchAddr, FlushIF=1, FlushID=1; stay in RUN.
    - LU and HALT in ID are ignored because the ID instruction is wrong-path.
  - LU:
    - StallIF=StallID=1 and BubbleEXE=1 for exactly 1 cycle; stay in RUN.
    - The hazard clears once the load advances.
  - ID opcode is HALT:
    - StallIF=1 and FlushIF=1; HALT proceeds down the pipe.
    - Go to HALT_DRAIN with the drain counter set to DRAIN_CYCLES.
- MEM_WAIT:
  - All four stalls stay asserted; the wait counter increments each cycle.
  - MemReady=1: go to RUN. Stalls still assert in that cycle and release the next.
  - MEM_TIMEOUT != 0 and the wait counter reaches MEM_TIMEOUT without MemReady: set MemError and go to HALTED.
- HALT_DRAIN:
  - StallIF=1 and FlushIF=1; the drain counter decrements each cycle. At 1, go to HALTED.
  - IsBranchTaken: the HALT was wrong-path. Redirect, FlushIF and FlushID as in RUN, then go to RUN.
  - MemReq & !MemReady: the drain counter holds and all stalls assert (no separate state).
- HALTED:
  - Halted=1; StallIF, StallID, IsStall, StallMEM all 1.
  - Exit only by rst.
- Counters:
  - CycleCount increments in every non-HALTED cycle.
  - StallCount increments in cycles with LU or memory-wait stalls.
  - Both saturate at all-ones; no wrap.
- rst asserted in any state, including mid-wait or mid-drain, returns to the reset values on the next edge.

Decomposition:
- Shared package or include file, extending ISA.v/params.v:
  - state encoding constants (PC_RUN, PC_MEM_WAIT, PC_HALT_DRAIN, PC_HALTED);
  - IR field bit positions;
  - a uses_rt(opcode) function;
  - an is_load(opcode) function.
- One natural sub-module, hazard_detect: combinational LU detection from IR_ID and IR_EXE, reusable by a future forwarding unit.
- FSM, counters and output logic stay in pipe_ctrl.

Test Plan:
1. LU stall: IR_EXE = LW with rt=5, IR_ID = ADD with rs=5 -> exactly 1 cycle of StallIF=StallID=BubbleEXE=1, then 0; StallCount=1. With rt=0 -> no stall.
2. Branch redirect: IsBranchTaken=1 with BranchAddr=0x0000_0040 in RUN, and a LU pattern present the same cycle -> Redirect=1, RedirectAddr=0x40, FlushIF=FlushID=1, BubbleEXE=0 for 1 cycle.
3. Memory wait: MemReq=1 with MemReady low for 4 cycles, then high -> IsStall=StallMEM=1 for 5 cycles, release on the 6th; StallCount=5; IsBranchTaken held during the wait redirects only after release.
4. Timeout: MEM_TIMEOUT=8, MemReq=1, MemReady=0 held -> MemError=1 and Halted=1 after 8 wait cycles; CycleCount stops incrementing.
5. Halt drain: HALT in ID -> HALT_DRAIN for 3 cycles then Halted=1. Repeat with IsBranchTaken=1 on the 2nd drain cycle -> Redirect, return to RUN, Halted stays 0.
6. Reset mid-operation: assert rst during MEM_WAIT and again during HALT_DRAIN -> next cycle state is RUN, all outputs 0, counters 0, MemError cleared.
